// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary quadrature encoder/decoder pair.
package rotary_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStep,
      StSettle
   } rot_state_e;

   typedef enum logic {
      DirCw,
      DirCcw
   } rot_dir_e;

   // Gray order indexed 0..3: 00, 01, 11, 10 (entry 0 in the low bits).
   localparam logic [7:0] GrayTable = {2'b10, 2'b11, 2'b01, 2'b00};

   function automatic logic [1:0] gray_code(input logic [1:0] idx);
      return GrayTable[{idx, 1'b0} +: 2];
   endfunction

   // Index wraps freely modulo 4 in either direction.
   function automatic logic [1:0] gray_next(input logic [1:0] idx, input rot_dir_e dir);
      return (dir == DirCw) ? idx + 2'd1 : idx - 2'd1;
   endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// Loadable down-counter that measures the dwell time of one quadrature phase.
module rotary_phase_timer #(
   parameter int unsigned PHASE_CYCLES = 50000,
   parameter int unsigned TW           = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          zero
);

   logic [TW-1:0] count_q, count_d;

   // Load wins; otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - TW'(1);
      end
   end

   // Counter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/rotary_quad_gen.sv
// Quadrature transmitter: turns CW/CCW step requests into a Gray-coded {B,A} waveform.
module rotary_quad_gen
   import rotary_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES  = 50000,
   parameter int unsigned DETENT_PHASES = 4,
   parameter int unsigned QUEUE_W       = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      step_cw,
   input  logic                      step_ccw,
   output logic [1:0]                rotary_out,
   output logic                      busy,
   output logic signed [QUEUE_W-1:0] pending,
   output logic                      dropped
);

   localparam int unsigned TimerW  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int unsigned PhasesW = $clog2(DETENT_PHASES + 1);
   localparam int unsigned SumW    = QUEUE_W + 2;

   localparam logic [TimerW-1:0]         Reload = TimerW'(PHASE_CYCLES - 1);
   localparam logic signed [SumW-1:0]    MaxPos = SumW'((1 << (QUEUE_W - 1)) - 1);
   localparam logic signed [SumW-1:0]    One    = SumW'(1);

   rot_state_e                 state_q, state_d;
   rot_dir_e                   dir_q, dir_d;
   logic [1:0]                 idx_q, idx_d;
   logic [PhasesW-1:0]         phases_q, phases_d;
   logic signed [QUEUE_W-1:0]  pending_q, pending_d;
   logic                       dropped_d;
   logic [1:0]                 rotary_q;
   logic                       busy_q;

   logic                       leave_idle;
   logic                       timer_load;
   logic                       timer_zero;
   logic signed [SumW-1:0]     pend_ext, d_ext, q_ext, sum_full, sum_noreq;

   rotary_phase_timer #(
      .PHASE_CYCLES (PHASE_CYCLES),
      .TW           (TimerW)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (timer_load),
      .load_val (Reload),
      .zero     (timer_zero)
   );

   assign leave_idle = (state_q == StIdle) && (pending_q != '0);

   // Net displacement queue: request delta plus dequeue, rejecting the request on saturation.
   always_comb begin
      pend_ext = {{2{pending_q[QUEUE_W-1]}}, pending_q};
      d_ext    = '0;
      if (step_cw && !step_ccw) begin
         d_ext = One;
      end else if (step_ccw && !step_cw) begin
         d_ext = -One;
      end
      q_ext = '0;
      if (leave_idle) begin
         q_ext = pending_q[QUEUE_W-1] ? One : -One;
      end
      sum_full  = pend_ext + d_ext + q_ext;
      sum_noreq = pend_ext + q_ext;
      pending_d = sum_full[QUEUE_W-1:0];
      dropped_d = 1'b0;
      if ((sum_full > MaxPos) || (sum_full < -MaxPos)) begin
         pending_d = sum_noreq[QUEUE_W-1:0];
         dropped_d = 1'b1;
      end
   end

   // Detent sequencer: hold each phase for PHASE_CYCLES edges, then settle before idling.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      idx_d      = idx_q;
      phases_d   = phases_q;
      timer_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pending_q != '0) begin
               dir_d      = pending_q[QUEUE_W-1] ? DirCcw : DirCw;
               phases_d   = PhasesW'(DETENT_PHASES);
               timer_load = 1'b1;
               state_d    = StStep;
            end
         end
         StStep: begin
            if (timer_zero) begin
               idx_d      = gray_next(idx_q, dir_q);
               phases_d   = phases_q - PhasesW'(1);
               timer_load = 1'b1;
               if (phases_q == PhasesW'(1)) begin
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (timer_zero) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // All state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         dir_q     <= DirCw;
         idx_q     <= 2'd0;
         phases_q  <= '0;
         pending_q <= '0;
         dropped   <= 1'b0;
         rotary_q  <= 2'b00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         idx_q     <= idx_d;
         phases_q  <= phases_d;
         pending_q <= pending_d;
         dropped   <= dropped_d;
         rotary_q  <= gray_code(idx_d);
         busy_q    <= (state_d != StIdle) || (pending_d != '0);
      end
   end

   assign rotary_out = rotary_q;
   assign busy       = busy_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Bench for rotary_quad_gen: schedule-based model, loopback decoder, directed vectors.
module tb_rotary_quad_gen;

   localparam int PC  = 4;
   localparam int DP  = 4;
   localparam int QW  = 3;
   localparam int MAX = 3;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 step_cw = 1'b0;
   logic                 step_ccw = 1'b0;
   logic [1:0]           rotary_out;
   logic                 busy;
   logic signed [QW-1:0] pending;
   logic                 dropped;

   int checks = 0;
   int failures = 0;

   rotary_quad_gen #(
      .PHASE_CYCLES  (PC),
      .DETENT_PHASES (DP),
      .QUEUE_W       (QW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_cw    (step_cw),
      .step_ccw   (step_ccw),
      .rotary_out (rotary_out),
      .busy       (busy),
      .pending    (pending),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] gray_of(input int p);
      case (p)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int pos_of(input logic [1:0] g);
      case (g)
         2'b00: return 0;
         2'b01: return 1;
         2'b11: return 2;
         default: return 3;
      endcase
   endfunction

   // Model: a detent that starts at edge s toggles at s+j*PC (j=1..DP) and idles at s+(DP+1)*PC.
   int n_q = 0, idle_at_q = -1, start_q = 0, dir_q = 1, pos_q = 0, mp_q = 0;
   int mdrop_q = 0, mbusy_q = 0;
   int nn, q, d, rel, mp_d, mdrop_d, start_d, dir_d, idle_at_d, pos_d, mbusy_d;
   logic idle_b, leave;

   always_comb begin
      nn     = n_q + 1;
      idle_b = (nn > idle_at_q);
      leave  = idle_b && (mp_q != 0);
      q      = leave ? ((mp_q > 0) ? -1 : 1) : 0;
      d      = int'(step_cw) - int'(step_ccw);
      mp_d   = mp_q + d + q;
      mdrop_d = 0;
      if (mp_d > MAX || mp_d < -MAX) begin
         mp_d    = mp_q + q;
         mdrop_d = 1;
      end
      start_d   = start_q;
      dir_d     = dir_q;
      idle_at_d = idle_at_q;
      pos_d     = pos_q;
      rel       = nn - start_q;
      if (leave) begin
         start_d   = nn;
         dir_d     = (mp_q > 0) ? 1 : -1;
         idle_at_d = nn + (DP + 1) * PC;
      end else if (!idle_b && rel > 0 && rel <= DP * PC && (rel % PC) == 0) begin
         pos_d = (pos_q + dir_q + 4) % 4;
      end
      mbusy_d = ((nn < idle_at_d) || (mp_d != 0)) ? 1 : 0;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mp_q      <= 0;
         mdrop_q   <= 0;
         pos_q     <= 0;
         mbusy_q   <= 0;
         idle_at_q <= n_q;
      end else begin
         n_q       <= nn;
         mp_q      <= mp_d;
         mdrop_q   <= mdrop_d;
         start_q   <= start_d;
         dir_q     <= dir_d;
         idle_at_q <= idle_at_d;
         pos_q     <= pos_d;
         mbusy_q   <= mbusy_d;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         check("cmp_rotary_out", int'(rotary_out), int'(gray_of(pos_q)));
         check("cmp_pending", int'($signed(pending)), mp_q);
         check("cmp_busy", int'(busy), mbusy_q);
         check("cmp_dropped", int'(dropped), mdrop_q);
      end
   end

   // Loopback decoder: counts completed detents returning to 00.
   logic [1:0] dec_prev = 2'b00;
   int dec_acc = 0, cw_cnt = 0, ccw_cnt = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         dec_prev <= 2'b00;
         dec_acc  <= 0;
      end else if (rotary_out != dec_prev) begin
         check("gray_one_bit", $countones(rotary_out ^ dec_prev), 1);
         if (rotary_out == 2'b00) begin
            if (dec_acc + ((((pos_of(rotary_out) - pos_of(dec_prev) + 4) % 4) == 1) ? 1 : -1) == 4)
               cw_cnt <= cw_cnt + 1;
            else if (dec_acc - 1 == -4)
               ccw_cnt <= ccw_cnt + 1;
            dec_acc <= 0;
         end else begin
            dec_acc <= dec_acc + ((((pos_of(rotary_out) - pos_of(dec_prev) + 4) % 4) == 1) ? 1 : -1);
         end
         dec_prev <= rotary_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy && k < max) begin
         tick();
         k++;
      end
      check("idle_reached", int'(busy), 0);
   endtask

   // One request, then literal checks on the waveform edges.
   task automatic run_single(input bit cw);
      logic [7:0] exp_seq;
      int c0, cc0, j;
      c0  = cw_cnt;
      cc0 = ccw_cnt;
      exp_seq = cw ? {2'b00, 2'b10, 2'b11, 2'b01} : {2'b00, 2'b01, 2'b11, 2'b10};
      step_cw  = cw;
      step_ccw = !cw;
      tick();
      step_cw  = 1'b0;
      step_ccw = 1'b0;
      check("single_pending_e0", int'($signed(pending)), cw ? 1 : -1);
      check("single_busy_e0", int'(busy), 1);
      for (int e = 1; e <= 21; e++) begin
         tick();
         if (e == 4) check("single_rot_e4", int'(rotary_out), 0);
         if (e == 5 || e == 9 || e == 13 || e == 17) begin
            j = (e - 5) / 4;
            check("single_rot_edge", int'(rotary_out), int'(exp_seq[2*j +: 2]));
         end
         if (e == 20) check("single_busy_e20", int'(busy), 1);
         if (e == 21) check("single_busy_e21", int'(busy), 0);
      end
      tick();
      check("single_cw_count", cw_cnt - c0, cw ? 1 : 0);
      check("single_ccw_count", ccw_cnt - cc0, cw ? 0 : 1);
   endtask

   initial begin
      int c0;
      int exp_pend[6] = '{1, 1, 2, 3, 3, 3};
      int exp_drop[6] = '{0, 0, 0, 0, 1, 1};

      // Reset
      repeat (3) tick();
      check("reset_rot", int'(rotary_out), 0);
      check("reset_pending", int'($signed(pending)), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_dropped", int'(dropped), 0);
      reset_n = 1'b1;
      repeat (2) tick();

      // Single CW and CCW detents
      run_single(1'b1);
      run_single(1'b0);

      // Simultaneous requests cancel
      step_cw  = 1'b1;
      step_ccw = 1'b1;
      tick();
      step_cw  = 1'b0;
      step_ccw = 1'b0;
      check("both_pending", int'($signed(pending)), 0);
      check("both_busy", int'(busy), 0);
      check("both_dropped", int'(dropped), 0);
      repeat (25) tick();
      check("both_rot", int'(rotary_out), 0);

      // Saturation while holding CW
      c0 = cw_cnt;
      step_cw = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("sat_pending", int'($signed(pending)), exp_pend[i]);
         check("sat_dropped", int'(dropped), exp_drop[i]);
      end
      step_cw = 1'b0;
      wait_idle(200);
      tick();
      check("sat_detents", cw_cnt - c0, 4);
      check("sat_pending_end", int'($signed(pending)), 0);

      // Opposite request cancels a queued step
      c0 = cw_cnt;
      step_cw = 1'b1;
      tick();
      tick();
      step_cw = 1'b0;
      tick();
      step_ccw = 1'b1;
      tick();
      step_ccw = 1'b0;
      check("cancel_pending", int'($signed(pending)), 0);
      wait_idle(100);
      tick();
      check("cancel_detents", cw_cnt - c0, 1);
      check("cancel_pending_end", int'($signed(pending)), 0);

      // Reset mid-detent
      step_cw = 1'b1;
      tick();
      step_cw = 1'b0;
      repeat (6) tick();
      check("mid_rot_before", int'(rotary_out), 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_reset_rot", int'(rotary_out), 0);
      check("mid_reset_busy", int'(busy), 0);
      check("mid_reset_pending", int'($signed(pending)), 0);
      tick();
      reset_n = 1'b1;
      repeat (25) tick();
      check("post_reset_rot", int'(rotary_out), 0);
      check("post_reset_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
